cacheline_burst_adaptor: RTL and testbench
==========================================

# cacheline_burst_adaptor

Memory-side responder for the cache's physical-memory port. It accepts a whole-line read or write request from the cache controller (`pmem_read`/`pmem_write`), breaks it into a fixed-length burst of narrower beats on the main-memory bus, and collects or sends those beats. When the line transfer completes, it returns a single-cycle `pmem_resp`. It sits between the cache datapath and the main-memory model, as the other end of the cache's `pmem_*` handshake.

## Interface
- `s_offset`, 5: line offset bits; the line is 2**`s_offset` bytes.
- `s_line`, 256: line width in bits (8*2**`s_offset`).
- `s_burst`, 64: beat width in bits.
- `burst_len`, `s_line`/`s_burst` = 4: number of beats per line.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset. Asynchronous and active-low; the block is in reset while `rst`=0.
- `pmem_read` in 1: line read request; held by the cache until `pmem_resp`.
- `pmem_write` in 1: line write request; held by the cache until `pmem_resp`.
- `pmem_address` in 32: line address.
- `pmem_wdata` in `s_line`: line to write.
- `pmem_rdata` out `s_line`: assembled read line.
- `pmem_resp` out 1: one-cycle completion pulse.
- `mem_read` out 1: burst read request.
- `mem_write` out 1: burst write request.
- `mem_address` out 32: line-aligned burst address.
- `mem_burst_o` out `s_burst`: current write beat.
- `mem_burst_i` in `s_burst`: read beat.
- `mem_resp` in 1: one beat transferred this cycle.

## Operation
- FSM states: IDLE, READ_BEATS, WRITE_BEATS, DONE. A beat counter has width log2(`burst_len`).
- **IDLE:**
  - If `pmem_read` is high: latch the address and go to READ_BEATS. Read wins if both requests are high.
  - Else if `pmem_write` is high: latch the address and `pmem_wdata`, then go to WRITE_BEATS.
  - On entry the counter is cleared to 0.
  - `mem_resp` is ignored.
- **Address latch:** the latched address is `pmem_address` with bits [`s_offset`-1:0] forced to 0. `mem_address` drives the latch in every state.
- **READ_BEATS:**
  - `mem_read`=1.
  - On each cycle with `mem_resp`=1: write `mem_burst_i` into line bits [`s_burst`*k +: `s_burst`], where k is the counter, then increment the counter.
  - On the beat with k=`burst_len`-1, go to DONE.
- **WRITE_BEATS:**
  - `mem_write`=1 and `mem_burst_o` = latched wdata beat k.
  - On `mem_resp`=1, increment k.
  - The beat with k=`burst_len`-1 goes to DONE.
- **DONE:** `pmem_resp`=1 for exactly this cycle, then go to IDLE unconditionally. Requests still high in DONE are ignored; the cache drops them the next cycle.
- **`pmem_rdata`:** the read-line register. It is updated only by read beats, is stable from DONE until the next read's first beat, and is unaffected by writes.
- **Gaps in `mem_resp`:** `mem_resp` may deassert between beats. The counter and outputs hold, and `mem_read`/`mem_write` stay asserted.
- **`mem_burst_o` outside WRITE_BEATS:** 0.

## Timing
- **Reset values:**
  - State is IDLE and the counter is 0.
  - `pmem_resp`, `mem_read`, `mem_write` are 0.
  - `mem_address`, `mem_burst_o`, `pmem_rdata` are all-zeros.
- **Reset mid-transfer:** the transfer is aborted, no `pmem_resp` is issued, and all outputs return to reset values immediately.
- **Request to bus:** a request sampled in IDLE at edge T0 gives `mem_read`/`mem_write` high from T0 until the edge that accepts the last beat.
- **Minimum latency** with `mem_resp` high every cycle:
  - Beats are accepted at T1..T4.
  - DONE (`pmem_resp`=1) occurs in the cycle after T4.
  - Back-to-back requests add one IDLE cycle.
- **Deassertion after the last beat:** `mem_read`/`mem_write` deassert in the DONE cycle. No extra beat is ever consumed.
- **Outputs:** all outputs are functions of registered state only. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset check:** hold `rst`=0 for 3 cycles, then release. Expect all outputs 0 and no `pmem_resp` while idle for 10 cycles.
- **Read, no gaps:** `pmem_read`, address 0x0000_1234; memory returns 0x11…11, 0x22…22, 0x33…33, 0x44…44 on consecutive cycles. Expect:
  - `mem_address`=0x0000_1220.
  - `pmem_rdata`={0x44…44,0x33…33,0x22…22,0x11…11}.
  - A single `pmem_resp` one cycle after the 4th beat.
- **Write with gaps:** `pmem_write` with wdata beats A,B,C,D; memory asserts `mem_resp` every other cycle. Expect:
  - `mem_burst_o` holds each beat until it is accepted.
  - Exactly 4 beats A–D in order.
  - `mem_write` drops in the DONE cycle and `pmem_resp` pulses once.
- **Writeback then load:** write followed immediately by a read, as the cache issues on a dirty miss. Expect two separate bursts, two `pmem_resp` pulses, and one IDLE cycle between them. `pmem_rdata` is unchanged by the write.
- **Simultaneous requests:** `pmem_read` and `pmem_write` both high. Expect a read burst only, with `mem_write` never asserted.
- **Reset mid-read:** assert `rst`=0 after 2 beats. Expect `mem_read`=0 immediately and no `pmem_resp`. A subsequent read completes normally with 4 fresh beats.

Source files
------------

// File: rtl/cacheline_burst_adaptor.sv
// rtl/cacheline_burst_adaptor.sv - splits whole-line pmem requests into fixed-length memory bursts
//
// Purpose: memory-side responder for the cache's physical-memory port. A line
// read or write from the cache is carried out as burst_len beats of s_burst
// bits on the main-memory bus. A single-cycle pmem_resp is returned once the
// whole line has moved.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   pmem_read/write   line request from the cache, held until pmem_resp
//   pmem_address      line address (offset bits are ignored)
//   pmem_wdata        line to write
//   pmem_rdata        assembled read line (updated only by read beats)
//   pmem_resp         one-cycle completion pulse
//   mem_read/write    burst request towards main memory
//   mem_address       line-aligned burst address
//   mem_burst_o       current write beat (0 outside write bursts)
//   mem_burst_i       incoming read beat
//   mem_resp          one beat transferred this cycle
module cacheline_burst_adaptor #(
  parameter int s_offset  = 5,
  parameter int s_line    = 8 * (2 ** s_offset),
  parameter int s_burst   = 64,
  parameter int burst_len = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [31:0]        pmem_address,
  input  logic [s_line-1:0]  pmem_wdata,
  output logic [s_line-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic               mem_read,
  output logic               mem_write,
  output logic [31:0]        mem_address,
  output logic [s_burst-1:0] mem_burst_o,
  input  logic [s_burst-1:0] mem_burst_i,
  input  logic               mem_resp
);

  localparam int cnt_w = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [31:0] offset_mask = (32'd1 << s_offset) - 32'd1;
  localparam logic [cnt_w-1:0] last_idx = cnt_w'(burst_len - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_BEATS  = 2'd1,
    WRITE_BEATS = 2'd2,
    DONE        = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [cnt_w-1:0]  count;
  logic [31:0]       addr_q;
  logic [s_line-1:0] wdata_q;
  logic [s_line-1:0] rdata_q;
  logic              last_beat;

  // A beat completes the line only when it is actually accepted.
  assign last_beat = mem_resp && (count == last_idx);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; read has priority over write when both are requested.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pmem_read) begin
          state_next = READ_BEATS;
        end else if (pmem_write) begin
          state_next = WRITE_BEATS;
        end
      end
      READ_BEATS: begin
        if (last_beat) begin
          state_next = DONE;
        end
      end
      WRITE_BEATS: begin
        if (last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Requests still held here are ignored; the cache drops them next cycle.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers: beat counter, address/wdata latches, read-line assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (pmem_read) begin
            addr_q <= pmem_address & ~offset_mask;
          end else if (pmem_write) begin
            addr_q  <= pmem_address & ~offset_mask;
            wdata_q <= pmem_wdata;
          end
        end
        READ_BEATS: begin
          if (mem_resp) begin
            rdata_q[count * s_burst +: s_burst] <= mem_burst_i;
            count <= count + 1'b1;
          end
        end
        WRITE_BEATS: begin
          if (mem_resp) begin
            count <= count + 1'b1;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  // Outputs depend on registered state only, so no input reaches an output
  // combinationally and reset clears every output immediately.
  always_comb begin
    pmem_resp   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_burst_o = '0;
    case (state)
      READ_BEATS: begin
        mem_read = 1'b1;
      end
      WRITE_BEATS: begin
        mem_write   = 1'b1;
        mem_burst_o = wdata_q[count * s_burst +: s_burst];
      end
      DONE: begin
        pmem_resp = 1'b1;
      end
      default: begin
        pmem_resp = 1'b0;
      end
    endcase
  end

  assign mem_address = addr_q;
  assign pmem_rdata  = rdata_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb/tb_cacheline_burst_adaptor.sv - randomized self-checking bench for cacheline_burst_adaptor
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_burst_o;
  logic [63:0]  mem_burst_i;
  logic         mem_resp;

  int n_cmp = 0;
  int n_err = 0;

  // Model: the line the cache should see on pmem_rdata.
  logic [255:0] model_rdata = '0;

  always #5 clk = ~clk;

  cacheline_burst_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_burst_o  (mem_burst_o),
    .mem_burst_i  (mem_burst_i),
    .mem_resp     (mem_resp)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand64(), rand64(), rand64(), rand64()};
  endfunction

  // Runs one line transfer, starting and ending at a falling edge in IDLE.
  // gap_mode: 0 = mem_resp every cycle, 1 = every other cycle, 2 = random.
  // abort_after > 0 resets the block once that many beats have been accepted.
  task automatic run_txn(input bit do_read, input bit do_write, input logic [31:0] addr,
                         input logic [255:0] wdata, input int gap_mode, input int abort_after,
                         input bit fixed_pat);
    logic [63:0]  beats[$];
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
    bit           is_read;
    bit           done;
    bit           toggle;
    bit           r;
    is_read  = do_read;
    exp_addr = (addr >> 5) << 5;
    done     = 1'b0;
    toggle   = 1'b0;
    pmem_read    = do_read;
    pmem_write   = do_write;
    pmem_address = addr;
    pmem_wdata   = wdata;
    mem_resp     = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      if (beats.size() == 4) begin
        check("resp_pulse", pmem_resp, 1);
        check("req_dropped_in_done", {mem_read, mem_write}, 0);
        if (gap_mode == 0) check("min_latency", cyc, 5);
        if (is_read) begin
          exp_line = '0;
          for (int i = 0; i < 4; i++) exp_line = exp_line | (256'(beats[i]) << (64 * i));
          model_rdata = exp_line;
        end
        check("rdata_at_done", pmem_rdata, model_rdata);
        done       = 1'b1;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        mem_resp   = 1'($urandom_range(0, 1));
      end else begin
        check("bus_addr", mem_address, exp_addr);
        check("bus_dir", {mem_read, mem_write}, is_read ? 2'b10 : 2'b01);
        check("no_early_resp", pmem_resp, 0);
        if (!is_read) begin
          check("wbeat", mem_burst_o, wdata[64 * beats.size() +: 64]);
          check("rdata_kept_on_write", pmem_rdata, model_rdata);
        end else begin
          check("burst_o_zero_on_read", mem_burst_o, 0);
        end
        if (abort_after > 0 && beats.size() == abort_after) begin
          rst = 1'b0;
          #1;
          check("abort_bus_idle", {mem_read, mem_write, pmem_resp}, 0);
          check("abort_addr", mem_address, 0);
          check("abort_rdata", pmem_rdata, 0);
          model_rdata = '0;
          pmem_read   = 1'b0;
          pmem_write  = 1'b0;
          mem_resp    = 1'b0;
          repeat (2) begin
            @(negedge clk);
            check("abort_no_resp", pmem_resp, 0);
          end
          rst = 1'b1;
          return;
        end
        case (gap_mode)
          0:       r = 1'b1;
          1:       begin toggle = !toggle; r = toggle; end
          default: r = 1'($urandom_range(0, 1));
        endcase
        mem_resp    = r;
        mem_burst_i = fixed_pat ? {16{4'(beats.size() + 1)}} : rand64();
        if (r) beats.push_back(is_read ? mem_burst_i : mem_burst_o);
      end
    end
    check("done_within_budget", done, 1);
    // One IDLE cycle follows DONE before the next request is sampled.
    @(negedge clk);
    check("idle_after_done", {pmem_resp, mem_read, mem_write}, 0);
    check("rdata_after_done", pmem_rdata, model_rdata);
    mem_resp = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int kind;
    rst          = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    mem_burst_i  = '0;
    mem_resp     = 1'b0;

    // Reset check
    repeat (3) @(negedge clk);
    check("rst_ctrl", {pmem_resp, mem_read, mem_write}, 0);
    check("rst_addr", mem_address, 0);
    check("rst_burst_o", mem_burst_o, 0);
    check("rst_rdata", pmem_rdata, 0);
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_quiet", {pmem_resp, mem_read, mem_write}, 0);
    end

    // Read, no gaps, fixed beat pattern
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 0, 0, 1'b1);
    check("read_pattern", pmem_rdata,
          {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111});

    // Write with alternating gaps
    run_txn(1'b0, 1'b1, 32'hDEAD_BEEF,
            {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA},
            1, 0, 1'b0);

    // Writeback then load
    run_txn(1'b0, 1'b1, $urandom, rand256(), 0, 0, 1'b0);
    run_txn(1'b1, 1'b0, $urandom, '0, 0, 0, 1'b0);

    // Simultaneous requests: read only
    run_txn(1'b1, 1'b1, $urandom, rand256(), 2, 0, 1'b0);

    // Reset mid-read, then a normal read
    run_txn(1'b1, 1'b0, $urandom, '0, 0, 2, 1'b0);
    run_txn(1'b1, 1'b0, $urandom, '0, 0, 0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      run_txn(kind != 1, kind != 0, $urandom, rand256(), $urandom_range(0, 2), 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
